// File: rtl/eq2_sweep_checker.sv
// Sweeps all 16 operand pairs into an external 2-bit equality comparator,
// holds each pair for DWELL cycles and counts the vectors whose answer is wrong.
module eq2_sweep_checker #(
    parameter int unsigned DWELL = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       aeqb,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_cnt,
    output logic       fail
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(DWELL - 1);

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [4:0]  err_nxt;
    logic        dwell_end;
    logic        mismatch;

    assign a         = idx[3:2];
    assign b         = idx[1:0];
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign fail      = done && (err_cnt != 5'd0);
    assign dwell_end = (cnt == LAST_CNT);
    assign mismatch  = (aeqb != (a == b));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = err_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    idx_nxt   = 4'd0;
                    cnt_nxt   = 16'd0;
                    err_nxt   = 5'd0;
                end
            end
            RUN: begin
                if (dwell_end) begin
                    // Saturate defensively; 16 checks per sweep cannot exceed the 5-bit range.
                    if (mismatch && (err_cnt != 5'd16)) err_nxt = err_cnt + 5'd1;
                    if (idx == 4'd15) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                        cnt_nxt = 16'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            cnt     <= 16'd0;
            err_cnt <= 5'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            err_cnt <= err_nxt;
        end
    end

endmodule

// File: doc/eq2_sweep_checker.md
EQ2_SWEEP_CHECKER -- requirements
Module: eq2_sweep_checker

Interface
REQ-001 The block SHALL have parameter DWELL, default 200, meaning clock cycles each test vector is held (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a sweep.
REQ-005 The block SHALL have port aeqb, input, 1, the equality result returned by the downstream 2-bit comparator.
REQ-006 The block SHALL have port a, output, 2, the first operand driven to the comparator.
REQ-007 The block SHALL have port b, output, 2, the second operand driven to the comparator.
REQ-008 The block SHALL have port busy, output, 1, high while a sweep is running.
REQ-009 The block SHALL have port done, output, 1, high from sweep completion until the next start or reset.
REQ-010 The block SHALL have port err_cnt, output, 5, the count of mismatched vectors in the current or last sweep.
REQ-011 The block SHALL have port fail, output, 1, equal to done AND (err_cnt != 0).

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 The block SHALL keep a 4-bit vector index idx and drive a = idx[3:2] and b = idx[1:0] from registers, so that all 16 operand pairs are covered in order 0..15.
REQ-014 In IDLE or DONE, start=1 SHALL take effect on the next edge: state RUN, idx=0, dwell counter=0, err_cnt=0, done=0, busy=1.
REQ-015 In RUN, start SHALL be ignored, with no restart and no effect on idx, counter or err_cnt.
REQ-016 In RUN, the dwell counter SHALL increment from 0 to DWELL-1 once per cycle while idx is held constant.
REQ-017 On the cycle where counter==DWELL-1, the block SHALL sample aeqb and compare it with the expected value (a==b); a mismatch increments err_cnt by 1 on that edge.
REQ-018 On that same edge, if idx<15 the block SHALL set idx=idx+1 and counter=0; if idx==15 it SHALL enter DONE with busy=0 and done=1.
REQ-019 err_cnt SHALL never exceed 16, because there are at most 16 checks per sweep, and SHALL not wrap.
REQ-020 done SHALL assert exactly 16*DWELL clock edges after the edge that accepted start.
REQ-021 In DONE, a and b SHALL hold 2'b11/2'b11, and err_cnt and fail SHALL hold until start or reset.
REQ-022 With DWELL=1, the block SHALL check every vector in the single cycle it is driven, presenting one vector per cycle.
REQ-023 aeqb SHALL be treated as a combinational function of a and b that settles within one cycle; the block SHALL apply no other synchronisation.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL set state=IDLE, idx=0, counter=0, a=0, b=0, busy=0, done=0, err_cnt=0 and fail=0.
REQ-025 Reset SHALL take priority over start and over any in-progress RUN activity on the same edge.
REQ-026 After reset is released mid-sweep, the block SHALL remain in IDLE until a new start, which restarts the sweep at idx=0.

Verification
REQ-027 DWELL=4, correct comparator, single start pulse -> done=1 exactly 64 edges later, err_cnt=0, fail=0, and a/b stepping 00/00, 00/01 ... 11/11 every 4 cycles.
REQ-028 DWELL=4, aeqb tied 0 -> done after 64 edges, err_cnt=4, fail=1.
REQ-029 DWELL=4, aeqb tied 1 -> err_cnt=12, fail=1; then a second start -> err_cnt cleared to 0 on the accepting edge and done deasserted.
REQ-030 DWELL=4, start re-pulsed at idx=5 during RUN -> no restart, and done still asserts 64 edges after the first start.
REQ-031 DWELL=4, reset asserted while idx=7 -> all outputs at reset values on the next edge; a later start gives a full 64-edge sweep from idx=0.
REQ-032 DWELL=1, correct comparator -> a/b change every cycle, done 16 edges after start, err_cnt=0.
